instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream fetch stage for the instruction memory system. Owns the program counter and drives the
//  memory byte address. Captures the returned instruction word into an IF/ID pipeline register.
//  Handles decode stall, branch/jump redirect with flush, and halts when the PC leaves the memory image.
// PARAMETERS
//  DATA_WIDTH    32            instruction/address width
//  MEMORY_DEPTH  32            instruction words in memory; valid PC range [RESET_PC, RESET_PC+4*MEMORY_DEPTH)
//  RESET_PC      32'h0040_0000 PC value after reset
//  NOP_INSTR     32'h0000_0000 bubble word inserted on flush/halt (MIPS sll $0,$0,0)
// PORTS
//  clk               in   1           clock; all state updates on rising edge
//  rst_n             in   1           asynchronous active-low reset
//  stall_i           in   1           hold PC and IF/ID register
//  redirect_i        in   1           branch/jump taken; 1-cycle pulse
//  redirect_pc_i     in   DATA_WIDTH  redirect target (byte address)
//  instr_data_i      in   DATA_WIDTH  instruction word from memory; combinational read of instr_addr_o
//  instr_addr_o      out  DATA_WIDTH  byte address to memory (= pc_q)
//  if_id_instr_o     out  DATA_WIDTH  registered instruction
//  if_id_pc_o        out  DATA_WIDTH  registered PC of if_id_instr_o
//  if_id_pc_plus4_o  out  DATA_WIDTH  registered PC+4
//  if_id_valid_o     out  1           IF/ID holds a real instruction
//  fault_o           out  1           level: fetch halted on out-of-range PC
//  misalign_o        out  1           1-cycle pulse: redirect target had [1:0]!=0
//  fetch_count_o     out  DATA_WIDTH  count of valid instructions loaded into IF/ID
// BEHAVIOUR
//  Reset (async assert, sync-released use): pc_q=RESET_PC. IF/ID instr=NOP_INSTR, pc=0, pc_plus4=0, valid=0.
//   Also fault_o=0, misalign_o=0, fetch_count_o=0, state=RUN. Reset mid-operation discards everything.
//  in_range = (pc_q >= RESET_PC) && (pc_q < RESET_PC + 4*MEMORY_DEPTH); unsigned compare, no overflow wrap.
//  FSM, 2 states:
//   RUN: normal fetch. -> HALT when !in_range and !redirect_i and !stall_i.
//   HALT: pc_q held; IF/ID loads NOP, valid=0; fault_o=1. -> RUN on redirect_i.
//  Next PC, priority high->low:
//   1. redirect_i: pc_q <= {redirect_pc_i[31:2],2'b00}.
//   2. stall_i: hold.
//   3. RUN: pc_q + 4, modulo 2^DATA_WIDTH.
//   4. HALT: hold.
//  IF/ID update, same priority:
//   redirect_i: flush; instr=NOP, valid=0. Overrides stall_i when both are high.
//   stall_i: hold all fields and valid.
//   RUN && in_range: instr=instr_data_i, pc=pc_q, pc_plus4=pc_q+4, valid=1, fetch_count_o += 1.
//   RUN && !in_range, or HALT: instr=NOP, valid=0.
//  misalign_o: registered; 1 for the cycle after a redirect with redirect_pc_i[1:0]!=0, else 0.
//  fault_o: registered; 1 while state==HALT; cleared the cycle after the redirect that leaves HALT.
//  Latency: instruction at PC appears on if_id_* one edge after instr_addr_o=PC. Redirect costs 1 bubble.
//  fetch_count_o wraps at 2^DATA_WIDTH; it does not increment on stall, flush or halt cycles.
//  Redirect into an out-of-range target: next cycle loads NOP (valid=0), then HALT.
// STRUCTURE
//  fetch_pkg: fetch_state_t {RUN,HALT}, NOP_INSTR, RESET_PC default, PC_INC=4.
//  Sub-module if_id_register: valid/instr/pc/pc_plus4 with load/flush/hold controls.
//  PC logic, FSM and counter stay in instruction_fetch_unit.
//  Top level instantiates this unit with memory_system_wrapper: instr_addr_o->address_i, ReadData->instr_data_i.
// TESTING
//  Reset release, no stall, mem returns addr^32'hA5A5_0000:
//   -> cycle 3 if_id_pc_o=0x0040_0008, valid=1, fetch_count_o=3.
//  stall_i high 2 cycles at pc 0x0040_000C:
//   -> instr_addr_o and IF/ID frozen, count unchanged; resumes at 0x0040_0010.
//  redirect_i with stall_i, target 0x0040_0040:
//   -> next cycle valid=0 and instr=0; instr_addr_o=0x0040_0040; then valid=1 with pc 0x0040_0040.
//  Redirect target 0x0040_0006 -> misalign_o pulses 1 cycle, instr_addr_o=0x0040_0004.
//  Run past 0x0040_007C (MEMORY_DEPTH=32) -> fault_o=1, valid=0, pc held at 0x0040_0080.
//   Redirect to 0x0040_0000 -> fault_o=0, fetch resumes.
//  Assert rst_n low mid-stream (not on clk edge):
//   -> outputs reset immediately; after release fetch restarts at RESET_PC with count 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] PC_INC            = 32'h0000_0004;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: bubble beats hold, hold beats load, otherwise a bubble is inserted.
module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int               DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bubble,
    input  logic                  hold,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    input  logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic [DATA_WIDTH-1:0] instr_q,
    output logic [DATA_WIDTH-1:0] pc_q,
    output logic [DATA_WIDTH-1:0] pc_plus4_q,
    output logic                  valid_q
);

    // Pipeline register update; PC fields are left untouched on a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= {DATA_WIDTH{1'b0}};
            pc_plus4_q <= {DATA_WIDTH{1'b0}};
            valid_q    <= 1'b0;
        end else if (bubble) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (hold) begin
            instr_q <= instr_q;
            valid_q <= valid_q;
        end else if (load) begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the memory address, fills IF/ID, and halts outside the image.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic [DATA_WIDTH-1:0] instr_data_i,
    output logic [DATA_WIDTH-1:0] instr_addr_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  fault_o,
    output logic                  misalign_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    // One extra bit keeps the upper bound from wrapping near the top of the address space.
    localparam logic [DATA_WIDTH:0] RANGE_LO = {1'b0, RESET_PC};
    localparam logic [DATA_WIDTH:0] RANGE_HI = RANGE_LO + ({1'b0, DATA_WIDTH'(MEMORY_DEPTH)} << 2'd2);
    localparam logic [DATA_WIDTH-1:0] COUNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    fetch_state_t          state_r, state_next_s;
    logic [DATA_WIDTH-1:0] pc_r, pc_next_s, pc_plus4_s, fetch_count_r;
    logic                  in_range_s, load_s, hold_s, bubble_s;
    logic                  fault_r, misalign_r;

    // Address range check and incremented PC.
    always_comb begin
        in_range_s = ({1'b0, pc_r} >= RANGE_LO) && ({1'b0, pc_r} < RANGE_HI);
        pc_plus4_s = pc_r + DATA_WIDTH'(PC_INC);
    end

    // Next PC, next state and IF/ID controls; the PC only advances on a real load, so it parks on the first out-of-range address.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        load_s       = 1'b0;
        hold_s       = 1'b0;
        bubble_s     = 1'b0;
        if (redirect_i) begin
            pc_next_s    = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            bubble_s     = 1'b1;
            state_next_s = ST_RUN;
        end else if (stall_i) begin
            hold_s = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (in_range_s) begin
                        pc_next_s = pc_plus4_s;
                        load_s    = 1'b1;
                    end else begin
                        bubble_s     = 1'b1;
                        state_next_s = ST_HALT;
                    end
                end
                ST_HALT: begin
                    bubble_s = 1'b1;
                end
                default: begin
                    bubble_s     = 1'b1;
                    state_next_s = ST_HALT;
                end
            endcase
        end
    end

    // Architectural state, fetch counter and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            fetch_count_r <= {DATA_WIDTH{1'b0}};
            fault_r       <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (load_s) begin
                fetch_count_r <= fetch_count_r + COUNT_ONE;
            end else begin
                fetch_count_r <= fetch_count_r;
            end
            fault_r    <= (state_next_s == ST_HALT);
            misalign_r <= redirect_i && is_misaligned(redirect_pc_i[1:0]);
        end
    end

    if_id_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .NOP_INSTR  (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .bubble     (bubble_s),
        .hold       (hold_s),
        .load       (load_s),
        .instr_d    (instr_data_i),
        .pc_d       (pc_r),
        .pc_plus4_d (pc_plus4_s),
        .instr_q    (if_id_instr_o),
        .pc_q       (if_id_pc_o),
        .pc_plus4_q (if_id_pc_plus4_o),
        .valid_q    (if_id_valid_o)
    );

    assign instr_addr_o  = pc_r;
    assign fault_o       = fault_r;
    assign misalign_o    = misalign_r;
    assign fetch_count_o = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a combinational memory returning addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_unit;

    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] TOP  = 32'h0040_0080;

    logic        clk, rst_n, stall, redirect;
    logic [31:0] redirect_pc, instr_data, instr_addr;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, fault, misalign;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] addr, instr, pc, pc4, count;
        logic        valid, fault, mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_count;
    logic        m_valid, m_halt, m_mis;

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .instr_data_i     (instr_data),
        .instr_addr_o     (instr_addr),
        .if_id_instr_o    (if_id_instr),
        .if_id_pc_o       (if_id_pc),
        .if_id_pc_plus4_o (if_id_pc_plus4),
        .if_id_valid_o    (if_id_valid),
        .fault_o          (fault),
        .misalign_o       (misalign),
        .fetch_count_o    (fetch_count)
    );

    assign instr_data = instr_addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = BASE; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
        m_count = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    endtask

    // Drive one cycle of inputs, push the predicted post-edge state, and step one edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        logic rng;
        stall = st; redirect = rd; redirect_pc = tgt;
        rng = (m_pc >= BASE) && (m_pc < TOP);
        m_mis = rd && (tgt[1:0] != 2'b00);
        if (rd) begin
            m_pc = {tgt[31:2], 2'b00}; m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (!m_halt && rng) begin
            m_instr = m_pc ^ KEY; m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_count = m_count + 32'd1; m_pc = m_pc + 32'd4;
        end else begin
            m_instr = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
        end
        e.addr = m_pc; e.instr = m_instr; e.pc = m_ifpc; e.pc4 = m_ifpc4; e.count = m_count;
        e.valid = m_valid; e.fault = m_halt; e.mis = m_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0;
    endtask

    // Scoreboard monitor: pops one prediction per edge once the DUT has updated.
    always @(posedge clk) begin
        #2;
        if (rst_n && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_total += 8;
            if (instr_addr !== mon_e.addr) $display("FAIL sb_addr got %h want %h", instr_addr, mon_e.addr); else n_pass++;
            if (if_id_instr !== mon_e.instr) $display("FAIL sb_instr got %h want %h", if_id_instr, mon_e.instr); else n_pass++;
            if (if_id_valid !== mon_e.valid) $display("FAIL sb_valid got %b want %b", if_id_valid, mon_e.valid); else n_pass++;
            if (fault !== mon_e.fault) $display("FAIL sb_fault got %b want %b", fault, mon_e.fault); else n_pass++;
            if (misalign !== mon_e.mis) $display("FAIL sb_misalign got %b want %b", misalign, mon_e.mis); else n_pass++;
            if (fetch_count !== mon_e.count) $display("FAIL sb_count got %0d want %0d", fetch_count, mon_e.count); else n_pass++;
            if (mon_e.valid && if_id_pc !== mon_e.pc) $display("FAIL sb_pc got %h want %h", if_id_pc, mon_e.pc); else n_pass++;
            if (mon_e.valid && if_id_pc_plus4 !== mon_e.pc4) $display("FAIL sb_pc4 got %h want %h", if_id_pc_plus4, mon_e.pc4); else n_pass++;
        end
    end

    task automatic test_reset();
        n_total += 6;
        if (instr_addr !== BASE) $display("FAIL rst_addr got %h want %h", instr_addr, BASE); else n_pass++;
        if (if_id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", if_id_valid); else n_pass++;
        if (if_id_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", if_id_instr); else n_pass++;
        if (fetch_count !== 32'h0) $display("FAIL rst_count got %0d want 0", fetch_count); else n_pass++;
        if (fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fault); else n_pass++;
        if (misalign !== 1'b0) $display("FAIL rst_misalign got %b want 0", misalign); else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
        n_total += 4;
        if (if_id_pc !== 32'h0040_0008) $display("FAIL seq_pc got %h want 00400008", if_id_pc); else n_pass++;
        if (if_id_valid !== 1'b1) $display("FAIL seq_valid got %b want 1", if_id_valid); else n_pass++;
        if (fetch_count !== 32'd3) $display("FAIL seq_count got %0d want 3", fetch_count); else n_pass++;
        if (if_id_instr !== (32'h0040_0008 ^ KEY)) $display("FAIL seq_instr got %h want %h", if_id_instr, 32'h0040_0008 ^ KEY); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            n_total += 3;
            if (instr_addr !== 32'h0040_000C) $display("FAIL stall_addr got %h want 0040000c", instr_addr); else n_pass++;
            if (if_id_pc !== 32'h0040_0008) $display("FAIL stall_pc got %h want 00400008", if_id_pc); else n_pass++;
            if (fetch_count !== 32'd3) $display("FAIL stall_count got %0d want 3", fetch_count); else n_pass++;
        end
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (if_id_pc !== 32'h0040_000C) $display("FAIL resume_pc got %h want 0040000c", if_id_pc); else n_pass++;
        if (instr_addr !== 32'h0040_0010) $display("FAIL resume_addr got %h want 00400010", instr_addr); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        cycle(1'b1, 1'b1, 32'h0040_0040);
        n_total += 3;
        if (if_id_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", if_id_valid); else n_pass++;
        if (if_id_instr !== 32'h0) $display("FAIL flush_instr got %h want 0", if_id_instr); else n_pass++;
        if (instr_addr !== 32'h0040_0040) $display("FAIL flush_addr got %h want 00400040", instr_addr); else n_pass++;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (if_id_valid !== 1'b1) $display("FAIL target_valid got %b want 1", if_id_valid); else n_pass++;
        if (if_id_pc !== 32'h0040_0040) $display("FAIL target_pc got %h want 00400040", if_id_pc); else n_pass++;
    endtask

    task automatic test_misalign();
        cycle(1'b0, 1'b1, 32'h0040_0006);
        n_total += 2;
        if (misalign !== 1'b1) $display("FAIL mis_pulse got %b want 1", misalign); else n_pass++;
        if (instr_addr !== 32'h0040_0004) $display("FAIL mis_addr got %h want 00400004", instr_addr); else n_pass++;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 1;
        if (misalign !== 1'b0) $display("FAIL mis_clear got %b want 0", misalign); else n_pass++;
    endtask

    task automatic test_halt();
        int budget;
        cycle(1'b0, 1'b1, 32'h0040_0070);
        budget = 0;
        while (fault !== 1'b1 && budget < 20) begin
            cycle(1'b0, 1'b0, 32'h0);
            budget++;
        end
        n_total += 3;
        if (fault !== 1'b1) $display("FAIL halt_timeout got fault=%b want 1", fault); else n_pass++;
        if (if_id_valid !== 1'b0) $display("FAIL halt_valid got %b want 0", if_id_valid); else n_pass++;
        if (instr_addr !== TOP) $display("FAIL halt_addr got %h want %h", instr_addr, TOP); else n_pass++;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 1;
        if (instr_addr !== TOP) $display("FAIL halt_hold got %h want %h", instr_addr, TOP); else n_pass++;
        cycle(1'b0, 1'b1, BASE);
        n_total += 2;
        if (fault !== 1'b0) $display("FAIL unhalt_fault got %b want 0", fault); else n_pass++;
        if (instr_addr !== BASE) $display("FAIL unhalt_addr got %h want %h", instr_addr, BASE); else n_pass++;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (if_id_valid !== 1'b1) $display("FAIL unhalt_valid got %b want 1", if_id_valid); else n_pass++;
        if (if_id_pc !== BASE) $display("FAIL unhalt_pc got %h want %h", if_id_pc, BASE); else n_pass++;
    endtask

    task automatic test_out_of_range_redirect();
        cycle(1'b0, 1'b1, 32'h0000_1000);
        n_total += 2;
        if (if_id_valid !== 1'b0) $display("FAIL oor_valid got %b want 0", if_id_valid); else n_pass++;
        if (fault !== 1'b0) $display("FAIL oor_fault_early got %b want 0", fault); else n_pass++;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (fault !== 1'b1) $display("FAIL oor_fault got %b want 1", fault); else n_pass++;
        if (instr_addr !== 32'h0000_1000) $display("FAIL oor_addr got %h want 00001000", instr_addr); else n_pass++;
        cycle(1'b0, 1'b1, 32'h0040_0010);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  BASE + 32'($urandom_range(0, 143)));
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (if_id_pc !== BASE) $display("FAIL rerun_pc got %h want %h", if_id_pc, BASE); else n_pass++;
        if (fetch_count !== 32'd1) $display("FAIL rerun_count got %0d want 1", fetch_count); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_halt();
        test_out_of_range_redirect();
        test_random();
        test_async_reset();
        cycle(1'b0, 1'b0, 32'h0);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
